// File: rtl/saturn_pkg.sv
// rtl/saturn_pkg.sv - shared types and defaults for the Saturn PC / return-stack unit
//
// Contents:
//   jr_state_t         jump FSM state (JR_IDLE, JR_COLLECT)
//   SATURN_ADDR_W      default PC / stack-entry width
//   SATURN_RSTK_DEPTH  default return-stack depth
//   SATURN_NIB_MAX     default maximum offset nibbles per jump
package saturn_pkg;

  typedef enum logic [0:0] {
    JR_IDLE    = 1'b0,
    JR_COLLECT = 1'b1
  } jr_state_t;

  localparam int SATURN_ADDR_W     = 20;
  localparam int SATURN_RSTK_DEPTH = 8;
  localparam int SATURN_NIB_MAX    = 5;

endpackage

// File: rtl/saturn_rstk_ring.sv
// rtl/saturn_rstk_ring.sv - circular return stack with saturating occupancy count
//
// Optional feature macro: SATURN_RSTK_DBG_EN (debug read path; tied to 0 when undefined)
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, pop      already qualified by the caller's active condition; never both
//   push_val       value written on push
//   pop_val        value a pop returns this cycle (0 when empty)
//   ptr, count     top-of-stack index and occupied entries
//   overflow       one-cycle pulse: push discarded the oldest entry
//   underflow      one-cycle pulse: pop found the stack empty
//   dbg_ptr        debug read index
//   dbg_val        combinational read of entry dbg_ptr
module saturn_rstk_ring
  import saturn_pkg::*;
#(
  parameter int ADDR_W = SATURN_ADDR_W,
  parameter int DEPTH  = SATURN_RSTK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_val,
  output logic [ADDR_W-1:0] pop_val,
  output logic [PTR_W-1:0]  ptr,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic [PTR_W-1:0]  dbg_ptr,
  output logic [ADDR_W-1:0] dbg_val
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr_inc;
  logic              full;

  assign ptr_inc = ptr + PTR_W'(1);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_val = (count != '0) ? mem[ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= PTR_W'(DEPTH - 1);
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Pulses clear on every edge, enabled or not.
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (push) begin
        ptr          <= ptr_inc;
        mem[ptr_inc] <= push_val;
        // When full, the slot after the top is the oldest entry; it is overwritten.
        if (full) overflow <= 1'b1;
        else      count    <= count + CNT_W'(1);
      end else if (pop) begin
        if (count != '0) begin
          mem[ptr] <= '0;
          ptr      <= ptr - PTR_W'(1);
          count    <= count - CNT_W'(1);
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

`ifdef SATURN_RSTK_DBG_EN
  assign dbg_val = mem[dbg_ptr];
`else
  logic unused_dbg;
  assign unused_dbg = ^dbg_ptr;
  assign dbg_val    = '0;
`endif

endmodule

// File: rtl/saturn_jump_rstk.sv
// rtl/saturn_jump_rstk.sv - Saturn program counter, nibble-serial jump assembler and return stack
//
// Optional feature macro: SATURN_RSTK_DBG_EN (enables i_dbg_ptr / o_dbg_val read path)
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_clk_en, i_stall       a cycle is active when i_clk_en && !i_stall
//   i_inc_pc                advance PC by 1
//   i_jump_start            begin a jump (IDLE only) with i_jump_len/i_jump_rel/i_jump_push
//   i_nibble(_valid)        offset nibbles, least significant first
//   i_rtn                   pop return stack into PC
//   i_load_pc, i_load_addr  load PC
//   o_pc                    current PC
//   o_busy                  collecting offset nibbles
//   o_jump_done             one-cycle pulse after PC took the jump target
//   o_rstk_ptr/count        top-of-stack index and occupancy
//   o_overflow/underflow    one-cycle stack fault pulses
//   i_dbg_ptr, o_dbg_val    debug stack read (combinational)
module saturn_jump_rstk
  import saturn_pkg::*;
#(
  parameter int ADDR_W     = SATURN_ADDR_W,
  parameter int RSTK_DEPTH = SATURN_RSTK_DEPTH,
  parameter int NIB_MAX    = SATURN_NIB_MAX,
  localparam int LEN_W     = $clog2(NIB_MAX + 1),
  localparam int PTR_W     = $clog2(RSTK_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clk_en,
  input  logic              i_stall,
  input  logic              i_inc_pc,
  input  logic              i_jump_start,
  input  logic [LEN_W-1:0]  i_jump_len,
  input  logic              i_jump_rel,
  input  logic              i_jump_push,
  input  logic [3:0]        i_nibble,
  input  logic              i_nibble_valid,
  input  logic              i_rtn,
  input  logic              i_load_pc,
  input  logic [ADDR_W-1:0] i_load_addr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_busy,
  output logic              o_jump_done,
  output logic [PTR_W-1:0]  o_rstk_ptr,
  output logic [CNT_W-1:0]  o_rstk_count,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic [PTR_W-1:0]  i_dbg_ptr,
  output logic [ADDR_W-1:0] o_dbg_val
);

  localparam int OFF_W = 4 * NIB_MAX;

  jr_state_t         state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] ret;
  logic [LEN_W-1:0]  len_q;
  logic              rel_q;
  logic              push_q;
  logic [LEN_W-1:0]  nib_cnt;
  logic [OFF_W-1:0]  offset;
  logic              jump_done;

  logic              active;
  logic              start;
  logic              final_nib;
  logic              do_pop;
  logic              do_push;
  logic [LEN_W-1:0]  len_in;
  logic [OFF_W-1:0]  off_next;
  logic [OFF_W-1:0]  off_ext;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pop_val;

  assign active    = i_clk_en && !i_stall;
  assign start     = active && (state == JR_IDLE) && i_jump_start;
  assign final_nib = active && (state == JR_COLLECT) && i_nibble_valid &&
                     (nib_cnt == len_q - LEN_W'(1));
  assign do_pop    = active && (state == JR_IDLE) && !i_jump_start && i_rtn;
  assign do_push   = final_nib && push_q;

  // Out-of-range lengths are clamped so the nibble counter always reaches len-1
  // inside the offset register.
  always_comb begin
    len_in = i_jump_len;
    if (i_jump_len == '0)                  len_in = LEN_W'(1);
    else if (i_jump_len > LEN_W'(NIB_MAX)) len_in = LEN_W'(NIB_MAX);
  end

  // Offset including the nibble arriving this cycle, so the final-nibble edge
  // can load the target directly.
  always_comb begin
    off_next = offset;
    off_next[4*int'(nib_cnt) +: 4] = i_nibble;
  end

  // Sign-extend from bit 4*len-1 for relative jumps.
  always_comb begin
    off_ext = '0;
    for (int b = 0; b < OFF_W; b++) begin
      off_ext[b] = (b < 4*int'(len_q)) ? off_next[b] : off_next[4*int'(len_q)-1];
    end
  end

  assign target = rel_q ? (base + off_ext[ADDR_W-1:0]) : off_next[ADDR_W-1:0];

  always_comb begin
    state_next = state;
    case (state)
      JR_IDLE:    if (start)     state_next = JR_COLLECT;
      JR_COLLECT: if (final_nib) state_next = JR_IDLE;
      default:                   state_next = JR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= JR_IDLE;
    else if (active) state <= state_next;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc        <= '0;
      base      <= '0;
      ret       <= '0;
      len_q     <= LEN_W'(1);
      rel_q     <= 1'b0;
      push_q    <= 1'b0;
      nib_cnt   <= '0;
      offset    <= '0;
      jump_done <= 1'b0;
    end else begin
      jump_done <= 1'b0;
      if (active) begin
        if (state == JR_IDLE) begin
          if (i_jump_start) begin
            len_q   <= len_in;
            rel_q   <= i_jump_rel;
            push_q  <= i_jump_push;
            base    <= pc;
            ret     <= pc + ADDR_W'(len_in);
            nib_cnt <= '0;
            offset  <= '0;
          end else if (i_rtn) begin
            pc <= pop_val;
          end else if (i_load_pc) begin
            pc <= i_load_addr;
          end else if (i_inc_pc) begin
            pc <= pc + ADDR_W'(1);
          end
        end else begin
          if (i_nibble_valid) begin
            offset  <= off_next;
            nib_cnt <= nib_cnt + LEN_W'(1);
          end
          if (final_nib) begin
            pc        <= target;
            jump_done <= 1'b1;
          end else if (i_inc_pc) begin
            pc <= pc + ADDR_W'(1);
          end
        end
      end
    end
  end

  saturn_rstk_ring #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RSTK_DEPTH)
  ) u_ring (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .push      (do_push),
    .pop       (do_pop),
    .push_val  (ret),
    .pop_val   (pop_val),
    .ptr       (o_rstk_ptr),
    .count     (o_rstk_count),
    .overflow  (o_overflow),
    .underflow (o_underflow),
    .dbg_ptr   (i_dbg_ptr),
    .dbg_val   (o_dbg_val)
  );

  assign o_pc        = pc;
  assign o_busy      = (state == JR_COLLECT);
  assign o_jump_done = jump_done;

endmodule

// File: tb/tb_saturn_jump_rstk.sv
// tb/tb_saturn_jump_rstk.sv - self-checking bench for saturn_jump_rstk
module tb_saturn_jump_rstk;

  localparam int AW = 20;

  localparam int C_INC = 1;
  localparam int C_JS  = 2;
  localparam int C_REL = 4;
  localparam int C_PSH = 8;
  localparam int C_NV  = 16;
  localparam int C_RTN = 32;
  localparam int C_LD  = 64;
  localparam int C_STL = 128;
  localparam int C_DIS = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en, stall, inc_pc, jump_start, jump_rel, jump_push;
  logic [2:0]    jump_len;
  logic [3:0]    nibble;
  logic          nibble_valid, rtn, load_pc;
  logic [AW-1:0] load_addr;
  logic [AW-1:0] pc;
  logic          busy, jump_done, overflow, underflow;
  logic [2:0]    rstk_ptr;
  logic [3:0]    rstk_count;
  logic [2:0]    dbg_ptr;
  logic [AW-1:0] dbg_val;

  saturn_jump_rstk dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(clk_en), .i_stall(stall),
    .i_inc_pc(inc_pc), .i_jump_start(jump_start), .i_jump_len(jump_len),
    .i_jump_rel(jump_rel), .i_jump_push(jump_push), .i_nibble(nibble),
    .i_nibble_valid(nibble_valid), .i_rtn(rtn), .i_load_pc(load_pc),
    .i_load_addr(load_addr), .o_pc(pc), .o_busy(busy), .o_jump_done(jump_done),
    .o_rstk_ptr(rstk_ptr), .o_rstk_count(rstk_count), .o_overflow(overflow),
    .o_underflow(underflow), .i_dbg_ptr(dbg_ptr), .o_dbg_val(dbg_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ctl; int len; int nib; int addr;
    int pc; int busy; int done; int cnt; int ptr; int ovf; int unf;
  } vec_t;

  typedef struct {
    int pc; int busy; int done; int cnt; int ptr; int ovf; int unf;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(input int ctl, len, nib, addr, pc, busy, done, cnt, ptr, ovf, unf);
    vec_t v;
    v.ctl = ctl; v.len = len; v.nib = nib; v.addr = addr;
    v.pc = pc; v.busy = busy; v.done = done; v.cnt = cnt; v.ptr = ptr; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".pc"},    int'(pc),         e.pc);
    chk({tag, ".busy"},  int'(busy),       e.busy);
    chk({tag, ".done"},  int'(jump_done),  e.done);
    chk({tag, ".count"}, int'(rstk_count), e.cnt);
    chk({tag, ".ptr"},   int'(rstk_ptr),   e.ptr);
    chk({tag, ".ovf"},   int'(overflow),   e.ovf);
    chk({tag, ".unf"},   int'(underflow),  e.unf);
  endtask

  task automatic drive(input vec_t v);
    logic [8:0] c;
    c = v.ctl[8:0];
    inc_pc       = c[0];
    jump_start   = c[1];
    jump_rel     = c[2];
    jump_push    = c[3];
    nibble_valid = c[4];
    rtn          = c[5];
    load_pc      = c[6];
    stall        = c[7];
    clk_en       = !c[8];
    jump_len     = v.len[2:0];
    nibble       = v.nib[3:0];
    load_addr    = v.addr[AW-1:0];
  endtask

  task automatic step(input string tag, input vec_t v);
    exp_t e;
    drive(v);
    e.pc = v.pc; e.busy = v.busy; e.done = v.done; e.cnt = v.cnt;
    e.ptr = v.ptr; e.ovf = v.ovf; e.unf = v.unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_state(tag, e);
  endtask

  vec_t tbl[28];
  exp_t r;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(C_INC,               0, 0,     0,    1,     0, 0, 0, 7, 0, 0);
    tbl[1]  = mk(C_INC,               0, 0,     0,    2,     0, 0, 0, 7, 0, 0);
    tbl[2]  = mk(C_INC,               0, 0,     0,    3,     0, 0, 0, 7, 0, 0);
    tbl[3]  = mk(C_LD,                0, 0,     'h100, 'h100, 0, 0, 0, 7, 0, 0);
    tbl[4]  = mk(C_JS|C_REL,          2, 0,     0,    'h100, 1, 0, 0, 7, 0, 0);
    tbl[5]  = mk(C_NV,                0, 'hE,   0,    'h100, 1, 0, 0, 7, 0, 0);
    tbl[6]  = mk(C_NV,                0, 'hF,   0,    'h0FE, 0, 1, 0, 7, 0, 0);
    tbl[7]  = mk(0,                   0, 0,     0,    'h0FE, 0, 0, 0, 7, 0, 0);
    tbl[8]  = mk(C_LD,                0, 0,     'h200, 'h200, 0, 0, 0, 7, 0, 0);
    tbl[9]  = mk(C_JS|C_REL|C_PSH,    4, 0,     0,    'h200, 1, 0, 0, 7, 0, 0);
    tbl[10] = mk(C_NV,                0, 0,     0,    'h200, 1, 0, 0, 7, 0, 0);
    tbl[11] = mk(C_NV,                0, 1,     0,    'h200, 1, 0, 0, 7, 0, 0);
    tbl[12] = mk(C_NV,                0, 0,     0,    'h200, 1, 0, 0, 7, 0, 0);
    tbl[13] = mk(C_NV,                0, 0,     0,    'h210, 0, 1, 1, 0, 0, 0);
    tbl[14] = mk(C_RTN,               0, 0,     0,    'h204, 0, 0, 0, 7, 0, 0);
    tbl[15] = mk(C_DIS|C_INC|C_RTN,   0, 0,     0,    'h204, 0, 0, 0, 7, 0, 0);
    tbl[16] = mk(C_STL|C_INC|C_LD,    0, 0,     'h55, 'h204, 0, 0, 0, 7, 0, 0);
    tbl[17] = mk(C_RTN|C_LD|C_INC,    0, 0,     'h777, 0,    0, 0, 0, 7, 0, 1);
    tbl[18] = mk(0,                   0, 0,     0,    0,     0, 0, 0, 7, 0, 0);
    tbl[19] = mk(C_LD,                0, 0,     'h50, 'h50,  0, 0, 0, 7, 0, 0);
    tbl[20] = mk(C_JS,                2, 0,     0,    'h50,  1, 0, 0, 7, 0, 0);
    tbl[21] = mk(C_NV|C_INC,          0, 3,     0,    'h51,  1, 0, 0, 7, 0, 0);
    tbl[22] = mk(C_NV|C_INC,          0, 0,     0,    'h03,  0, 1, 0, 7, 0, 0);
    tbl[23] = mk(C_JS|C_REL,          1, 0,     0,    'h03,  1, 0, 0, 7, 0, 0);
    tbl[24] = mk(C_NV,                0, 'hF,   0,    'h02,  0, 1, 0, 7, 0, 0);
    tbl[25] = mk(C_JS|C_PSH|C_RTN|C_LD, 1, 0,   'h999, 'h02, 1, 0, 0, 7, 0, 0);
    tbl[26] = mk(C_NV|C_JS|C_RTN|C_LD, 3, 9,    'h888, 'h09, 0, 1, 1, 0, 0, 0);
    tbl[27] = mk(C_RTN,               0, 0,     0,    'h03,  0, 0, 0, 7, 0, 0);

    dbg_ptr = '0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    r = '{pc: 0, busy: 0, done: 0, cnt: 0, ptr: 7, ovf: 0, unf: 0};
    chk_state("reset", r);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) step($sformatf("row%0d", i), tbl[i]);

    // Nine GOSUBs: each pushes (0x0FFF+i)+1 and jumps to 0.
    for (int i = 0; i < 9; i++) begin
      step($sformatf("ovf%0d.ld", i), mk(C_LD, 0, 0, 'h0FFF + i, 'h0FFF + i, 0, 0,
                                         (i > 8) ? 8 : i, (i + 7) % 8, 0, 0));
      step($sformatf("ovf%0d.js", i), mk(C_JS|C_PSH, 1, 0, 0, 'h0FFF + i, 1, 0,
                                         i, (i + 7) % 8, 0, 0));
      step($sformatf("ovf%0d.nv", i), mk(C_NV, 0, 0, 0, 0, 0, 1,
                                         (i + 1 > 8) ? 8 : i + 1, i % 8, (i == 8) ? 1 : 0, 0));
    end
    for (int j = 0; j < 8; j++)
      step($sformatf("pop%0d", j), mk(C_RTN, 0, 0, 0, 'h1008 - j, 0, 0, 7 - j, 7 - j, 0, 0));
    step("pop_empty", mk(C_RTN, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("pop_after", mk(0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Absolute len=5 jump with a stalled nibble cycle.
    step("abs.js", mk(C_JS,        5, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step("abs.n0", mk(C_NV,        0, 5, 0, 0, 1, 0, 0, 0, 0, 0));
    step("abs.n1", mk(C_NV,        0, 4, 0, 0, 1, 0, 0, 0, 0, 0));
    step("abs.st", mk(C_NV|C_STL,  0, 9, 0, 0, 1, 0, 0, 0, 0, 0));
    step("abs.n2", mk(C_NV,        0, 3, 0, 0, 1, 0, 0, 0, 0, 0));
    step("abs.n3", mk(C_NV,        0, 2, 0, 0, 1, 0, 0, 0, 0, 0));
    step("abs.n4", mk(C_NV,        0, 1, 0, 'h12345, 0, 1, 0, 0, 0, 0));

    // Reset in the middle of a push-jump.
    step("rst.ld", mk(C_LD,             0, 0, 'h400, 'h400, 0, 0, 0, 0, 0, 0));
    step("rst.js", mk(C_JS|C_REL|C_PSH, 3, 0, 0,     'h400, 1, 0, 0, 0, 0, 0));
    step("rst.n0", mk(C_NV,             0, 1, 0,     'h400, 1, 0, 0, 0, 0, 0));
    step("rst.n1", mk(C_NV,             0, 2, 0,     'h400, 1, 0, 0, 0, 0, 0));
    drive(mk(C_NV, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    r = '{pc: 0, busy: 0, done: 0, cnt: 0, ptr: 7, ovf: 0, unf: 0};
    chk_state("rst.async", r);
    @(posedge clk);
    #1;
    chk_state("rst.held", r);
    rst_n = 1'b1;
    step("post.js",  mk(C_JS|C_PSH, 1, 0, 0, 0, 1, 0, 0, 7, 0, 0));
    step("post.nv",  mk(C_NV,       0, 7, 0, 7, 0, 1, 1, 0, 0, 0));
    dbg_ptr = 3'd0;
    #1;
`ifdef SATURN_RSTK_DBG_EN
    chk("dbg.rstk0", int'(dbg_val), 1);
`else
    chk("dbg.tied", int'(dbg_val), 0);
`endif
    step("post.rtn", mk(C_RTN,      0, 0, 0, 1, 0, 0, 0, 7, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/saturn_jump_rstk.md
# saturn_jump_rstk

Parametrised successor to the Saturn PC/return-stack unit. Owns the program counter, assembles nibble-serial jump offsets (relative or absolute), and maintains a circular return stack of configurable depth with Saturn overflow/underflow semantics. It sits between the instruction decoder, which issues jump, return and PC-load commands, and the bus controller, which consumes `o_pc`. The stack is a true circular buffer with a saturating occupancy count rather than a bare pointer.

## Interface
- `ADDR_W`, 20, PC and stack-entry width in bits; must be ≤ 4·`NIB_MAX`.
- `RSTK_DEPTH`, 8, return-stack entries; power of two, ≥ 2.
- `NIB_MAX`, 5, maximum offset nibbles per jump.
- `LEN_W`, `$clog2(NIB_MAX+1)`, derived width of the length field.

Ports:
- `i_clk` in 1: clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_clk_en` in 1: global enable. Nothing changes state when it is low.
- `i_stall` in 1: bus or exec unit busy. Nothing changes state when it is high.
- `i_inc_pc` in 1: advance PC by 1.
- `i_jump_start` in 1: begin a jump (IDLE only).
- `i_jump_len` in `LEN_W`: offset nibble count, 1..`NIB_MAX`.
- `i_jump_rel` in 1: 1 = relative (signed), 0 = absolute.
- `i_jump_push` in 1: push return address (GOSUB).
- `i_nibble` in 4: offset nibble, LSN first.
- `i_nibble_valid` in 1: `i_nibble` is valid this cycle.
- `i_rtn` in 1: pop stack into PC.
- `i_load_pc` in 1: load PC from `i_load_addr`.
- `i_load_addr` in `ADDR_W`: PC load value.
- `o_pc` out `ADDR_W`: current PC.
- `o_busy` out 1: in COLLECT.
- `o_jump_done` out 1: one-cycle pulse after the PC has taken the jump target.
- `o_rstk_ptr` out `$clog2(RSTK_DEPTH)`: top-of-stack index.
- `o_rstk_count` out `$clog2(RSTK_DEPTH)+1`: occupied entries.
- `o_overflow` out 1: pulse when a push discarded the oldest entry.
- `o_underflow` out 1: pulse when a pop found the stack empty.
- `i_dbg_ptr` in `$clog2(RSTK_DEPTH)`: debug read index.
- `o_dbg_val` out `ADDR_W`: `RSTK[i_dbg_ptr]`, combinational.

## Operation
- A cycle is **active** when `i_clk_en && !i_stall`. All updates below happen only on active cycles.
- **FSM: IDLE.**
  - `i_jump_start` latches `len`, `rel`, `push`, sets `base` = `o_pc`, sets `ret` = `o_pc + len`, clears the nibble counter, and moves to COLLECT.
  - Otherwise, in priority order: `i_rtn`, then `i_load_pc`, then `i_inc_pc`.
- **FSM: COLLECT.**
  - Each `i_nibble_valid` shifts the nibble into bits [4k+3:4k] of the offset, where k is the counter value.
  - On the nibble with k = len−1:
    - relative: PC ← `base` + sign-extend(offset[4·len−1:0]), modulo 2^`ADDR_W`.
    - absolute: PC ← zero-extend(offset), truncated to `ADDR_W`.
    - If `push` is set, `ret` is pushed.
    - FSM returns to IDLE.
  - `i_inc_pc` is honoured during COLLECT except on the final-nibble cycle, where the jump wins.
  - `i_rtn`, `i_load_pc` and `i_jump_start` are ignored during COLLECT.
- **Push:**
  - ptr ← ptr+1 (wraps), then `RSTK[ptr]` ← value.
  - count ← min(count+1, `RSTK_DEPTH`).
  - If count was already `RSTK_DEPTH`, the oldest entry is overwritten and `o_overflow` pulses.
- **Pop (`i_rtn`):**
  - count > 0: PC ← `RSTK[ptr]`, `RSTK[ptr]` ← 0, ptr ← ptr−1 (wraps), count−1.
  - count = 0: PC ← 0, ptr unchanged, `o_underflow` pulses.
- **Asynchronous reset:** PC=0, ptr=`RSTK_DEPTH`−1, count=0, all entries 0, FSM=IDLE, all pulses 0. Reset mid-COLLECT abandons the jump; no push occurs.

## Timing
- All outputs are registered except `o_dbg_val`.
- Jump latency: `o_pc` shows the target on the clock edge that samples the final nibble. `o_jump_done` is high during the cycle that follows that edge.
- `o_busy` rises the cycle after the start edge and falls on the final-nibble edge.
- A `len`=1 jump spends exactly one cycle in COLLECT, assuming the nibble is valid.
- RTN: single cycle. `o_pc` is updated on the sampling edge.
- `o_overflow`, `o_underflow` and `o_jump_done` are high for exactly one cycle and cleared on the next active or inactive edge.
- Stalled or disabled cycles freeze state. Pulses still clear.

## Configuration
- Macro `SATURN_RSTK_DBG_EN`.
- Defined: the `i_dbg_ptr`/`o_dbg_val` read path is present.
- Undefined: the ports still exist, `o_dbg_val` is tied to 0, and `i_dbg_ptr` is unused.

## Structure
- Shared package `saturn_pkg` holds:
  - FSM state enum (`JR_IDLE`, `JR_COLLECT`).
  - Default `ADDR_W`, `RSTK_DEPTH`, `NIB_MAX` constants.
- Sub-module `saturn_rstk_ring`: circular buffer, pointer, saturating count, overflow/underflow flags, and debug read.
- The parent module holds the PC, the FSM and the offset assembler.

## Test plan
- Reset, then 3× `i_inc_pc` → `o_pc`=0x00003, `o_rstk_count`=0, `o_rstk_ptr`=7.
- PC=0x00100, relative jump, len=2, nibbles 0xE, 0xF (offset −2) → `o_pc`=0x000FE, `o_jump_done` pulse, no push.
- PC=0x00200, relative jump, len=4, push, nibbles 0,1,0,0 (+0x10) → `o_pc`=0x00210, `RSTK[0]`=0x00204, count=1. Then `i_rtn` → `o_pc`=0x00204, count=0, `RSTK[0]`=0.
- 9 pushes of 0x1000+i (i=0..8) → count=8, `o_overflow` pulses once (on the 9th). 8 pops return 0x1008 down to 0x1001. A 9th pop → `o_pc`=0, `o_underflow` pulses.
- Absolute jump, len=5, nibbles 5,4,3,2,1, with `i_stall` high on the 3rd nibble cycle → stalled nibble not consumed, final `o_pc`=0x12345.
- `i_reset_n` low after 2 nibbles of a push-jump → `o_pc`=0, `o_busy`=0, count=0. After release, a new jump works normally.
